// File: rtl/pulse_capture_pkg.sv
// Shared definitions for the pulse capture block: FSM encoding and the
// smallest parameter values the logic is built to handle.
package pulse_capture_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int MIN_COUNTER_SIZE = 4;
  localparam int MIN_SYNC_STAGES  = 2;

endpackage

// File: rtl/pulse_capture_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus a history flop that
// turns the synchronized level into single-cycle rise/fall event pulses.
module sync_edge
  import pulse_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic sig_sync,
  output logic rise_evt,
  output logic fall_evt
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("sync_edge: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
  end

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_chain <= '0;
      hist       <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], sig_in};
      hist       <= sync_chain[SYNC_STAGES-1];
    end
  end

  // Events are combinational from the last sync stage and the history flop,
  // so each one is exactly one cycle wide.
  assign sig_sync = sync_chain[SYNC_STAGES-1];
  assign rise_evt = sig_sync & ~hist;
  assign fall_evt = ~sig_sync & hist;

endmodule

// File: rtl/pulse_capture.sv
// Measures period and high time of an asynchronous input in clk cycles and
// presents each measurement through a one-entry valid/ready holding register.
module pulse_capture
  import pulse_capture_pkg::*;
#(
  parameter int COUNTER_SIZE = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    sig_in,
  input  logic                    result_ready,
  output logic                    result_valid,
  output logic [COUNTER_SIZE-1:0] period,
  output logic [COUNTER_SIZE-1:0] high_time,
  output logic                    saturated,
  output logic                    missed
);

  if (COUNTER_SIZE < MIN_COUNTER_SIZE) begin : g_bad_width
    $error("pulse_capture: COUNTER_SIZE must be at least %0d", MIN_COUNTER_SIZE);
  end

  localparam logic [COUNTER_SIZE-1:0] CNT_MAX = '1;
  localparam logic [COUNTER_SIZE-1:0] CNT_ONE = COUNTER_SIZE'(1);

  state_t                  state;
  logic [COUNTER_SIZE-1:0] cnt;
  logic [COUNTER_SIZE-1:0] high_lat;
  logic                    sat_flag;
  logic                    sig_sync;
  logic                    rise_evt;
  logic                    fall_evt;
  logic                    complete;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .sig_in  (sig_in),
    .sig_sync(sig_sync),
    .rise_evt(rise_evt),
    .fall_evt(fall_evt)
  );

  assign complete = enable && (state == MEASURE) && rise_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      high_lat <= '0;
      sat_flag <= 1'b0;
    end else if (!enable) begin
      state    <= IDLE;
      cnt      <= '0;
      high_lat <= '0;
      sat_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise_evt) begin
            cnt      <= CNT_ONE;
            sat_flag <= 1'b0;
            state    <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise_evt) begin
            cnt      <= CNT_ONE;
            sat_flag <= 1'b0;
          end else begin
            // Count sticks at all-ones; the flag records that it got there.
            if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
            if (cnt >= CNT_MAX - CNT_ONE) sat_flag <= 1'b1;
          end
          if (fall_evt) high_lat <= cnt;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output holding register; it ignores enable so a held result survives a disable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_valid <= 1'b0;
      period       <= '0;
      high_time    <= '0;
      saturated    <= 1'b0;
      missed       <= 1'b0;
    end else begin
      missed <= 1'b0;
      if (complete) begin
        if (!result_valid || result_ready) begin
          result_valid <= 1'b1;
          period       <= cnt;
          high_time    <= high_lat;
          saturated    <= sat_flag;
        end else begin
          missed <= 1'b1;
        end
      end else if (result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_capture.sv
// Directed bench for pulse_capture: a 32-bit instance for the main scenarios
// and a 4-bit instance for counter saturation.
module tb_pulse_capture;
  import pulse_capture_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        sig = 1'b0;
  logic        sig4 = 1'b0;
  logic        ready = 1'b0;

  logic        valid, sat, missed;
  logic [31:0] per, hi;
  logic        valid4, sat4, missed4;
  logic [3:0]  per4, hi4;

  int n_cmp = 0;
  int n_bad = 0;
  int missed_cnt = 0;
  logic [31:0] q_per[$];
  logic [31:0] q_hi[$];
  logic [31:0] q_sat[$];
  logic [31:0] q4_per[$];
  logic [31:0] q4_hi[$];
  logic [31:0] q4_sat[$];

  pulse_capture #(.COUNTER_SIZE(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig),
    .result_ready(ready), .result_valid(valid), .period(per),
    .high_time(hi), .saturated(sat), .missed(missed)
  );

  pulse_capture #(.COUNTER_SIZE(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig4),
    .result_ready(ready), .result_valid(valid4), .period(per4),
    .high_time(hi4), .saturated(sat4), .missed(missed4)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so at negedge they already
  // hold the values the next posedge will act on.
  always @(negedge clk) begin
    if (!reset) begin
      if (missed) missed_cnt++;
      if (valid && ready) begin
        q_per.push_back(per);
        q_hi.push_back(hi);
        q_sat.push_back(32'(sat));
        $display("xfer   dut: period=%0d high_time=%0d saturated=%0d", per, hi, sat);
      end
      if (valid4 && ready) begin
        q4_per.push_back(32'(per4));
        q4_hi.push_back(32'(hi4));
        q4_sat.push_back(32'(sat4));
        $display("xfer  dut4: period=%0d high_time=%0d saturated=%0d", per4, hi4, sat4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel4, input logic lvl, input int n);
    if (sel4) sig4 = lvl;
    else sig = lvl;
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_xfer(input int idx, input int p, input int h, input int s);
    check($sformatf("xfer%0d_period", idx), (idx < q_per.size()) ? q_per[idx] : 32'hDEAD_BEEF, 32'(p));
    check($sformatf("xfer%0d_high", idx), (idx < q_hi.size()) ? q_hi[idx] : 32'hDEAD_BEEF, 32'(h));
    check($sformatf("xfer%0d_sat", idx), (idx < q_sat.size()) ? q_sat[idx] : 32'hDEAD_BEEF, 32'(s));
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_valid", 32'(valid), 0);
    check("rst_period", per, 0);
    check("rst_high", hi, 0);
    check("rst_sat", 32'(sat), 0);
    check("rst_missed", 32'(missed), 0);
    check("rst_state", 32'(dut.state), 32'(IDLE));

    // Square wave 4 high / 6 low, ready held: 5 rises -> 4 results
    enable = 1'b1;
    ready  = 1'b1;
    repeat (5) begin
      drive(0, 1'b1, 4);
      drive(0, 1'b0, 6);
    end
    check("sq_count", 32'(q_per.size()), 4);
    for (int i = 0; i < 4; i++) check_xfer(i, 10, 4, 0);
    check("sq_missed", 32'(missed_cnt), 0);

    // 4-bit counter: high 3, low 30 -> saturates at 15
    drive(1, 1'b1, 3);
    drive(1, 1'b0, 30);
    drive(1, 1'b1, 3);
    drive(1, 1'b0, 3);
    check("sat_count", 32'(q4_per.size()), 1);
    check("sat_period", (q4_per.size() > 0) ? q4_per[0] : 32'hDEAD_BEEF, 15);
    check("sat_high", (q4_hi.size() > 0) ? q4_hi[0] : 32'hDEAD_BEEF, 3);
    check("sat_flag", (q4_sat.size() > 0) ? q4_sat[0] : 32'hDEAD_BEEF, 1);

    // Period 8 with ready low: first result held, two later ones missed
    enable = 1'b0;
    tick();
    enable = 1'b1;
    ready  = 1'b0;
    repeat (3) begin
      drive(0, 1'b1, 4);
      drive(0, 1'b0, 4);
    end
    drive(0, 1'b1, 4);
    drive(0, 1'b0, 4);
    check("hold_valid", 32'(valid), 1);
    check("hold_period", per, 8);
    check("hold_high", hi, 4);
    check("hold_missed", 32'(missed_cnt), 2);
    check("hold_noxfer", 32'(q_per.size()), 4);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("deliver_count", 32'(q_per.size()), 5);
    check_xfer(4, 8, 4, 0);
    check("deliver_valid", 32'(valid), 0);

    // Ready pulsed exactly in the completion cycle of the next edge
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 2);
    drive(0, 1'b0, 5);
    check("b_valid", 32'(valid), 1);
    check("b_period", per, 12);
    sig = 1'b1;
    tick();
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("swap_valid", 32'(valid), 1);
    check("swap_period", per, 7);
    check("swap_high", hi, 2);
    check("swap_missed", 32'(missed_cnt), 2);
    check("swap_count", 32'(q_per.size()), 6);
    check_xfer(5, 12, 4, 0);

    // Disable mid-high phase: held result survives, then two rises needed
    enable = 1'b0;
    tick();
    tick();
    check("dis_state", 32'(dut.state), 32'(IDLE));
    check("dis_valid", 32'(valid), 1);
    check("dis_period", per, 7);
    enable = 1'b1;
    ready  = 1'b1;
    drive(0, 1'b1, 1);
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 3);
    drive(0, 1'b0, 3);
    check("reen_count", 32'(q_per.size()), 7);
    check_xfer(6, 7, 2, 0);
    check("reen_valid", 32'(valid), 0);
    drive(0, 1'b1, 2);
    drive(0, 1'b0, 4);
    check("reen2_count", 32'(q_per.size()), 8);
    check_xfer(7, 6, 3, 0);

    // Asynchronous reset between clock edges mid-measurement
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(valid), 0);
    check("arst_period", per, 0);
    check("arst_high", hi, 0);
    check("arst_state", 32'(dut.state), 32'(IDLE));
    check("arst_cnt", dut.cnt, 0);
    check("arst_period4", 32'(per4), 0);
    check("arst_sat4", 32'(sat4), 0);
    #10;
    reset = 1'b0;
    tick();
    check("post_rst_missed", 32'(missed), 0);

    // After reset the first rise only starts a measurement
    drive(0, 1'b1, 3);
    drive(0, 1'b0, 3);
    check("post_rst_one_rise", 32'(q_per.size()), 8);
    drive(0, 1'b1, 3);
    drive(0, 1'b0, 4);
    check("post_rst_two_rise", 32'(q_per.size()), 9);
    check_xfer(8, 6, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
